// File: rtl/hash_verifier_pkg.sv
// -----------------------------------------------------------------------------
// hash_verifier_pkg
// Shared constants, types and helper functions for the hash_verifier block:
//   IV_DEFAULT   - chaining-state initial value
//   ROUND_CONST  - per-round additive constant (low nibble XORed with round no.)
//   ROT_D/ROT_B  - rotation amounts applied to the d and b words
//   state_t      - FSM state encoding (IDLE / MIX / CMP)
//   rotl32       - 32-bit rotate-left
//   round_const  - round constant for a given round index
// No ports (package).
// -----------------------------------------------------------------------------
package hash_verifier_pkg;

  localparam logic [127:0] IV_DEFAULT  = 128'h6A09E667_BB67AE85_3C6EF372_A54FF53A;
  localparam logic [31:0]  ROUND_CONST = 32'h9E3779B9;
  localparam int unsigned  ROT_D       = 16;
  localparam int unsigned  ROT_B       = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] round_const(input logic [3:0] r);
    return ROUND_CONST ^ {28'h0, r};
  endfunction

endpackage

// File: rtl/hash_verifier_if.sv
// -----------------------------------------------------------------------------
// hash_verifier_if
// Block-stream and verdict bundle of the hash_verifier.
//   blk_valid  (m->s)  blk_data / blk_last / exp_digest valid
//   blk_ready  (s->m)  engine can accept a block
//   blk_data   (m->s)  128-bit message block, d0 = [127:96] .. d3 = [31:0]
//   blk_last   (m->s)  final block of the message
//   exp_digest (m->s)  expected digest, sampled when the last block is accepted
//   done       (s->m)  one-cycle verdict pulse
//   match      (s->m)  computed digest equals expected digest
//   digest_out (s->m)  computed digest
// Modports: master = block source / verdict sink, slave = the engine.
// -----------------------------------------------------------------------------
interface hash_verifier_if;

  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         blk_last;
  logic [127:0] exp_digest;
  logic         done;
  logic         match;
  logic [127:0] digest_out;

  modport master (
    output blk_valid, blk_data, blk_last, exp_digest,
    input  blk_ready, done, match, digest_out
  );

  modport slave (
    input  blk_valid, blk_data, blk_last, exp_digest,
    output blk_ready, done, match, digest_out
  );

endinterface

// File: rtl/arx_round.sv
// -----------------------------------------------------------------------------
// arx_round
// Purely combinational single ARX mixing round.
//   a_i..d_i  in   32  current state words
//   r_i       in    4  round index (folded into the round constant)
//   a_o..d_o  out  32  next state words, already rotated so that
//                      {a_o,b_o,c_o,d_o} = {b',c',d',a'}
// All additions are modulo 2^32.
// -----------------------------------------------------------------------------
module arx_round
  import hash_verifier_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [3:0]  r_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [31:0] c_s;
  logic [31:0] d_s;

  // Round function: each step consumes the freshly updated word of the previous step.
  always_comb begin
    a_s = a_i + b_i + round_const(r_i);
    d_s = rotl32(d_i ^ a_s, ROT_D);
    c_s = c_i + d_s;
    b_s = rotl32(b_i ^ c_s, ROT_B);
  end

  // Word rotation between rounds: the new b lands in the a slot, and so on.
  assign a_o = b_s;
  assign b_o = c_s;
  assign c_o = d_s;
  assign d_o = a_s;

endmodule

// File: rtl/hash_verifier.sv
// -----------------------------------------------------------------------------
// hash_verifier
// Iterative ARX digest engine with a constant-time digest comparator.
// Each accepted 128-bit block is XORed into the chaining state and mixed for
// ROUNDS cycles; after the last block the state is compared against the
// expected digest latched with that block.
// Parameters:
//   ROUNDS  mixing rounds per block, 1..15
//   IV      chaining-state initial value
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  hash_verifier_if.slave  block stream in, verdict out
// -----------------------------------------------------------------------------
module hash_verifier
  import hash_verifier_pkg::*;
#(
  parameter int unsigned  ROUNDS = 8,
  parameter logic [127:0] IV     = IV_DEFAULT
)
(
  input  logic           clk,
  input  logic           rst,
  hash_verifier_if.slave bus
);

  localparam logic [3:0] LAST_R = 4'(ROUNDS - 1);

  // FSM
  state_t       state_q;
  state_t       state_d;

  // Chaining state, round counter, message flags
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [31:0]  a_d, b_d, c_d, d_d;
  logic [3:0]   r_q, r_d;
  logic         last_q, last_d;
  logic [127:0] exp_q, exp_d;

  // Verdict registers
  logic         done_q, done_d;
  logic         match_q, match_d;
  logic [127:0] digest_q, digest_d;

  // Control decoded from state
  logic         blk_ready_s;
  logic         mix_en_s;
  logic         cmp_en_s;
  logic         accept_s;
  logic         last_round_s;

  // Round datapath and comparator
  logic [31:0]  ra_s, rb_s, rc_s, rd_s;
  logic [127:0] diff_s;
  logic         equal_s;

  arx_round u_round (
    .a_i (a_q),
    .b_i (b_q),
    .c_i (c_q),
    .d_i (d_q),
    .r_i (r_q),
    .a_o (ra_s),
    .b_o (rb_s),
    .c_o (rc_s),
    .d_o (rd_s)
  );

  assign accept_s     = bus.blk_valid & blk_ready_s;
  assign last_round_s = (r_q == LAST_R);

  // Full-width XOR then OR-reduce: every bit always participates, so the
  // verdict takes the same path and time whatever the data.
  assign diff_s  = {a_q, b_q, c_q, d_q} ^ exp_q;
  assign equal_s = ~|diff_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_MIX;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MIX: begin
        if (last_round_s) begin
          if (last_q) begin
            state_d = ST_CMP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_MIX;
        end
      end
      ST_CMP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: decoded purely from the state, so blk_ready has no path from blk_valid.
  always_comb begin
    blk_ready_s = 1'b0;
    mix_en_s    = 1'b0;
    cmp_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        blk_ready_s = 1'b1;
      end
      ST_MIX: begin
        mix_en_s = 1'b1;
      end
      ST_CMP: begin
        cmp_en_s = 1'b1;
      end
      default: begin
        blk_ready_s = 1'b0;
      end
    endcase
  end

  // Datapath next-state: absorb on acceptance, mix in MIX, verdict + IV reload in CMP.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    r_d      = r_q;
    last_d   = last_q;
    exp_d    = exp_q;
    done_d   = 1'b0;
    match_d  = match_q;
    digest_d = digest_q;

    if (accept_s) begin
      a_d    = a_q ^ bus.blk_data[127:96];
      b_d    = b_q ^ bus.blk_data[95:64];
      c_d    = c_q ^ bus.blk_data[63:32];
      d_d    = d_q ^ bus.blk_data[31:0];
      r_d    = 4'd0;
      last_d = bus.blk_last;
      if (bus.blk_last) begin
        exp_d = bus.exp_digest;
      end else begin
        exp_d = exp_q;
      end
    end else if (mix_en_s) begin
      a_d = ra_s;
      b_d = rb_s;
      c_d = rc_s;
      d_d = rd_s;
      r_d = r_q + 4'd1;
    end else if (cmp_en_s) begin
      digest_d = {a_q, b_q, c_q, d_q};
      match_d  = equal_s;
      done_d   = 1'b1;
      {a_d, b_d, c_d, d_d} = IV;
      r_d      = 4'd0;
      last_d   = 1'b0;
    end else begin
      done_d = 1'b0;
    end
  end

  // Datapath and verdict registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {a_q, b_q, c_q, d_q} <= IV;
      r_q      <= 4'd0;
      last_q   <= 1'b0;
      exp_q    <= 128'h0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
      digest_q <= 128'h0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      r_q      <= r_d;
      last_q   <= last_d;
      exp_q    <= exp_d;
      done_q   <= done_d;
      match_q  <= match_d;
      digest_q <= digest_d;
    end
  end

  assign bus.blk_ready  = blk_ready_s;
  assign bus.done       = done_q;
  assign bus.match      = match_q;
  assign bus.digest_out = digest_q;

endmodule

// File: tb/tb_hash_verifier.sv
// -----------------------------------------------------------------------------
// tb_hash_verifier
// Self-checking bench for hash_verifier: directed and randomized messages
// compared against a word-level reference model of the digest.
// -----------------------------------------------------------------------------
module tb_hash_verifier;

  localparam int           ROUNDS = 8;
  localparam logic [127:0] IV     = 128'h6A09E667_BB67AE85_3C6EF372_A54FF53A;
  localparam logic [31:0]  K      = 32'h9E3779B9;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hash_verifier_if bus();

  hash_verifier #(.ROUNDS(ROUNDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int done_seen = 0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Digest of a one- or two-block message, from the textual round rules.
  function automatic logic [127:0] model(input logic [127:0] m0, input logic [127:0] m1, input int nblk);
    logic [127:0] st;
    logic [31:0]  w [4];
    logic [31:0]  na, nb, nc, nd;
    st = IV;
    for (int k = 0; k < nblk; k++) begin
      st = st ^ ((k == 0) ? m0 : m1);
      w[0] = st[127:96]; w[1] = st[95:64]; w[2] = st[63:32]; w[3] = st[31:0];
      for (int r = 0; r < ROUNDS; r++) begin
        na = w[0] + w[1] + (K ^ 32'(r));
        nd = rl(w[3] ^ na, 16);
        nc = w[2] + nd;
        nb = rl(w[1] ^ nc, 12);
        w[0] = nb; w[1] = nc; w[2] = nd; w[3] = na;
      end
      st = {w[0], w[1], w[2], w[3]};
    end
    return st;
  endfunction

  task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Sends a message and reports acceptance, latencies (edges after the first
  // acceptance), the number of done samples and the verdict.
  task automatic run_msg(input logic [127:0] b0, input logic [127:0] b1, input int n,
                         input logic [127:0] expd, output logic acc1, output int lat2,
                         output int latd, output int pulses, output logic m,
                         output logic [127:0] dg);
    int   g;
    logic rdy;
    logic acc2;
    acc1 = 1'b0; acc2 = 1'b0; lat2 = -1; latd = -1; pulses = 0; m = 1'bx; dg = 'x;
    bus.blk_valid  = 1'b1;
    bus.blk_data   = b0;
    bus.blk_last   = (n == 1);
    bus.exp_digest = expd;
    g = 0;
    while (!acc1 && g < 50) begin
      @(negedge clk); rdy = bus.blk_ready;
      @(posedge clk); #1;
      g++;
      if (rdy === 1'b1) acc1 = 1'b1;
    end
    if (!acc1) begin
      bus.blk_valid = 1'b0;
      return;
    end
    if (n == 2) begin
      // Valid stays high through MIX with the second block waiting.
      bus.blk_data = b1; bus.blk_last = 1'b1; bus.exp_digest = expd;
    end else begin
      bus.blk_valid = 1'b0; bus.blk_data = rnd128(); bus.exp_digest = rnd128();
    end
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk); rdy = bus.blk_ready;
      @(posedge clk); #1;
      if (n == 2 && !acc2 && rdy === 1'b1) begin
        acc2 = 1'b1; lat2 = e;
        bus.blk_valid = 1'b0; bus.blk_data = rnd128();
        bus.blk_last = 1'($urandom()); bus.exp_digest = rnd128();
      end
      if (bus.done === 1'b1) begin
        pulses++;
        if (latd < 0) begin
          latd = e; m = bus.match; dg = bus.digest_out;
        end
      end
      if (latd >= 0 && e >= latd + 2) break;
    end
    bus.blk_valid = 1'b0;
  endtask

  initial begin
    logic         acc1, m;
    logic [127:0] dg, ref_s, ref_2, expd, one, b0, b1;
    int           lat2, latd, pulses, g, ds0, n, flip;
    logic         rdy;

    rst = 1'b1;
    bus.blk_valid = 1'b0; bus.blk_data = 128'h0; bus.blk_last = 1'b0; bus.exp_digest = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_int("reset_ready", int'(bus.blk_ready), 1);
    chk_int("reset_done", int'(bus.done), 0);
    chk_int("reset_match", int'(bus.match), 0);
    chk_vec("reset_digest", bus.digest_out, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single block, matching expectation
    ref_s = model(128'h0, 128'h0, 1);
    run_msg(128'h0, 128'h0, 1, ref_s, acc1, lat2, latd, pulses, m, dg);
    chk_int("single_accept", int'(acc1), 1);
    chk_int("single_latency", latd, 9);
    chk_int("single_pulses", pulses, 1);
    chk_int("single_match", int'(m), 1);
    chk_vec("single_digest", dg, ref_s);

    // Same message, expected digest with bit 0 flipped
    run_msg(128'h0, 128'h0, 1, ref_s ^ 128'h1, acc1, lat2, latd, pulses, m, dg);
    chk_int("mismatch_latency", latd, 9);
    chk_int("mismatch_pulses", pulses, 1);
    chk_int("mismatch_match", int'(m), 0);
    chk_vec("mismatch_digest", dg, ref_s);

    // Two-block message with valid held high
    b0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    b1 = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
    ref_2 = model(b0, b1, 2);
    run_msg(b0, b1, 2, ref_2, acc1, lat2, latd, pulses, m, dg);
    chk_int("two_second_accept", lat2, 9);
    chk_int("two_latency", latd, 18);
    chk_int("two_pulses", pulses, 1);
    chk_int("two_match", int'(m), 1);
    chk_vec("two_digest", dg, ref_2);

    // Reset in the middle of MIX
    bus.blk_valid = 1'b1; bus.blk_data = 128'h0; bus.blk_last = 1'b1; bus.exp_digest = ref_s;
    g = 0; acc1 = 1'b0;
    while (!acc1 && g < 50) begin
      @(negedge clk); rdy = bus.blk_ready;
      @(posedge clk); #1;
      g++;
      if (rdy === 1'b1) acc1 = 1'b1;
    end
    chk_int("rstmix_accept", int'(acc1), 1);
    bus.blk_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    ds0 = done_seen;
    rst = 1'b1;
    #2;
    chk_int("rstmix_async_ready", int'(bus.blk_ready), 1);
    chk_int("rstmix_async_match", int'(bus.match), 0);
    chk_vec("rstmix_async_digest", bus.digest_out, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_int("rstmix_ready", int'(bus.blk_ready), 1);
    chk_int("rstmix_done", int'(bus.done), 0);
    chk_int("rstmix_match", int'(bus.match), 0);
    chk_vec("rstmix_digest", bus.digest_out, 128'h0);
    repeat (12) @(posedge clk);
    #1;
    chk_int("rstmix_no_done", done_seen - ds0, 0);
    run_msg(128'h0, 128'h0, 1, ref_s, acc1, lat2, latd, pulses, m, dg);
    chk_int("resend_latency", latd, 9);
    chk_int("resend_match", int'(m), 1);
    chk_vec("resend_digest", dg, ref_s);

    // Randomized messages
    one = 128'h1;
    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(2, 1));
      flip = int'($urandom_range(1, 0));
      b0 = rnd128();
      b1 = rnd128();
      ref_s = model(b0, b1, n);
      expd = (flip != 0) ? (ref_s ^ (one << $urandom_range(127, 0))) : ref_s;
      run_msg(b0, b1, n, expd, acc1, lat2, latd, pulses, m, dg);
      chk_int("rand_latency", latd, (n == 2) ? 18 : 9);
      chk_int("rand_pulses", pulses, 1);
      chk_int("rand_match", int'(m), (flip != 0) ? 0 : 1);
      chk_vec("rand_digest", dg, ref_s);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
